// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the streaming complex FIR decimator.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_MAC    = 2'd1,
    ST_OUTPUT = 2'd2
  } fir_state_t;

  function automatic int acc_width(input int data_width, input int tap_count);
    return 2 * data_width + $clog2(tap_count) + 2;
  endfunction

  // The saturation helper works on fixed 128/64-bit containers, so wider configs are rejected.
  function automatic bit cfg_ok(input int data_width, input int tap_count,
                                input int mult_per_cycle, input int decimation);
    return (mult_per_cycle > 0) && (tap_count > 0) && (tap_count % mult_per_cycle == 0)
           && (decimation >= 1) && (data_width <= 64)
           && (acc_width(data_width, tap_count) <= 128);
  endfunction

  function automatic logic signed [63:0] shift_sat(input logic signed [127:0] acc,
                                                   input int frac_bits, input int data_width);
    logic signed [127:0] shifted;
    logic signed [127:0] max_v;
    logic signed [127:0] min_v;
    shifted = acc >>> frac_bits;
    max_v   = (128'sd1 <<< (data_width - 1)) - 128'sd1;
    min_v   = -(128'sd1 <<< (data_width - 1));
    if (shifted > max_v) begin
      return 64'(max_v);
    end else if (shifted < min_v) begin
      return 64'(min_v);
    end else begin
      return 64'(shifted);
    end
  endfunction

endpackage

// File: rtl/cmplx_mac_lane.sv
// One complex tap product h*x; the one extra bit keeps the re/im sums exact.
module cmplx_mac_lane
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] h_re,
  input  logic signed [DATA_WIDTH-1:0] h_im,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] x_q,
  output logic signed [2*DATA_WIDTH:0] p_re,
  output logic signed [2*DATA_WIDTH:0] p_im
);

  logic signed [2*DATA_WIDTH-1:0] re_i;
  logic signed [2*DATA_WIDTH-1:0] im_q;
  logic signed [2*DATA_WIDTH-1:0] re_q;
  logic signed [2*DATA_WIDTH-1:0] im_i;

  assign re_i = h_re * x_i;
  assign im_q = h_im * x_q;
  assign re_q = h_re * x_q;
  assign im_i = h_im * x_i;

  assign p_re = {re_i[2*DATA_WIDTH-1], re_i} - {im_q[2*DATA_WIDTH-1], im_q};
  assign p_im = {re_q[2*DATA_WIDTH-1], re_q} + {im_i[2*DATA_WIDTH-1], im_i};

endmodule

// File: rtl/fir_complex_stream.sv
// Streaming complex-coefficient FIR decimator with a time-multiplexed MAC,
// run-time coefficient loading and saturated fixed-point output.
module fir_complex_stream
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int TAP_COUNT         = 20,
  parameter int MULT_PER_CYCLE    = 1,
  parameter int DECIMATION_FACTOR = 1,
  parameter int FRAC_BITS         = 10,
  localparam int AW = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  input  logic signed [DATA_WIDTH-1:0] in_q,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         coef_wr,
  input  logic [AW-1:0]                coef_addr,
  input  logic signed [DATA_WIDTH-1:0] coef_re,
  input  logic signed [DATA_WIDTH-1:0] coef_im,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic signed [DATA_WIDTH-1:0] out_q,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, TAP_COUNT);
  localparam int PROD_W = 2 * DATA_WIDTH + 1;
  localparam int DEC_W  = (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;
  localparam logic [AW:0]      TAP_LIM   = (AW + 1)'(TAP_COUNT);
  localparam logic [AW-1:0]    LAST_BASE = AW'(TAP_COUNT - MULT_PER_CYCLE);
  localparam logic [AW-1:0]    STEP      = AW'(MULT_PER_CYCLE);
  localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'(DECIMATION_FACTOR - 1);

  if (!cfg_ok(DATA_WIDTH, TAP_COUNT, MULT_PER_CYCLE, DECIMATION_FACTOR)) begin : g_bad_cfg
    $error("fir_complex_stream: unsupported parameter combination");
  end

  fir_state_t                   state;
  logic signed [DATA_WIDTH-1:0] delay_i [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] delay_q [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] tap_re  [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] tap_im  [TAP_COUNT];
  logic [AW-1:0]                base;
  logic [DEC_W-1:0]             dec_cnt;
  logic signed [ACC_W-1:0]      acc_i;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0]      sum_i;
  logic signed [ACC_W-1:0]      sum_q;
  logic [AW-1:0]                lane_idx [MULT_PER_CYCLE];
  logic signed [PROD_W-1:0]     p_re     [MULT_PER_CYCLE];
  logic signed [PROD_W-1:0]     p_im     [MULT_PER_CYCLE];

  // Lane n of the current block handles tap base+n.
  for (genvar n = 0; n < MULT_PER_CYCLE; n++) begin : g_lane
    assign lane_idx[n] = base + AW'(n);
    cmplx_mac_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .h_re (tap_re[lane_idx[n]]),
      .h_im (tap_im[lane_idx[n]]),
      .x_i  (delay_i[lane_idx[n]]),
      .x_q  (delay_q[lane_idx[n]]),
      .p_re (p_re[n]),
      .p_im (p_im[n])
    );
  end

  always_comb begin
    sum_i = acc_i;
    sum_q = acc_q;
    for (int n = 0; n < MULT_PER_CYCLE; n++) begin
      sum_i = sum_i + ACC_W'(p_re[n]);
      sum_q = sum_q + ACC_W'(p_im[n]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_ACCEPT;
      base      <= '0;
      dec_cnt   <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      for (int k = 0; k < TAP_COUNT; k++) begin
        delay_i[k] <= '0;
        delay_q[k] <= '0;
        tap_re[k]  <= '0;
        tap_im[k]  <= '0;
      end
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (coef_wr && ({1'b0, coef_addr} < TAP_LIM)) begin
            tap_re[coef_addr] <= coef_re;
            tap_im[coef_addr] <= coef_im;
          end
          if (in_valid && in_ready) begin
            delay_i[0] <= in_i;
            delay_q[0] <= in_q;
            for (int k = 1; k < TAP_COUNT; k++) begin
              delay_i[k] <= delay_i[k-1];
              delay_q[k] <= delay_q[k-1];
            end
            if (dec_cnt == DEC_LAST) begin
              dec_cnt  <= '0;
              acc_i    <= '0;
              acc_q    <= '0;
              base     <= '0;
              in_ready <= 1'b0;
              state    <= ST_MAC;
            end else begin
              dec_cnt <= dec_cnt + DEC_W'(1);
            end
          end
        end
        ST_MAC: begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          if (base == LAST_BASE) begin
            state <= ST_OUTPUT;
          end else begin
            base <= base + STEP;
          end
        end
        // First OUTPUT cycle loads the result; later cycles wait for the handshake.
        ST_OUTPUT: begin
          if (!out_valid) begin
            out_i     <= DATA_WIDTH'(shift_sat(128'(acc_i), FRAC_BITS, DATA_WIDTH));
            out_q     <= DATA_WIDTH'(shift_sat(128'(acc_q), FRAC_BITS, DATA_WIDTH));
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_ACCEPT;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_ACCEPT;
        end
      endcase
    end
  end

endmodule
